// File: rtl/mux_select_sequencer_if.sv
// mux_select_sequencer_if: control and mux-pin bundle for the select sequencer.
// The direction signal exists only when MUX_SEQ_DIRECTION_EN is defined.
interface mux_select_sequencer_if;
  logic       run;
  logic [3:0] channel_mask;
`ifdef MUX_SEQ_DIRECTION_EN
  logic       direction;
`endif
  logic       force_en;
  logic [1:0] force_select;
  logic [1:0] select;
  logic       enable;
  logic       step_pulse;
  logic       wrap_pulse;

  modport master (
    output run,
    output channel_mask,
`ifdef MUX_SEQ_DIRECTION_EN
    output direction,
`endif
    output force_en,
    output force_select,
    input  select,
    input  enable,
    input  step_pulse,
    input  wrap_pulse
  );

  modport slave (
    input  run,
    input  channel_mask,
`ifdef MUX_SEQ_DIRECTION_EN
    input  direction,
`endif
    input  force_en,
    input  force_select,
    output select,
    output enable,
    output step_pulse,
    output wrap_pulse
  );
endinterface

// File: rtl/mux_select_sequencer.sv
// mux_select_sequencer: round-robin select/enable sequencer for a 4:1 mux.
// Define MUX_SEQ_DIRECTION_EN to add a descending-scan direction input.
module mux_select_sequencer #(
  parameter int DWELL_CYCLES = 1000,
  parameter int CNT_WIDTH    = 10
) (
  input logic                   clock,
  input logic                   reset,
  mux_select_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FORCED
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST =
    CNT_WIDTH'(DWELL_CYCLES - 1);

  state_t               r_state, w_state;
  logic [1:0]           r_sel, w_sel;
  logic                 r_en, w_en;
  logic                 r_step, w_step;
  logic                 r_wrap, w_wrap;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt;
  logic                 w_dir;
  logic [1:0]           w_first;
  logic [1:0]           w_next;
  logic [1:0]           w_idx;
  logic                 w_next_wrap;

`ifdef MUX_SEQ_DIRECTION_EN
  assign w_dir = bus.direction;
`else
  assign w_dir = 1'b0;
`endif

  // Start channel: lowest set bit ascending, highest descending.
  always_comb begin
    w_first = 2'd0;
    if (w_dir) begin
      for (int i = 0; i < 4; i++)
        if (bus.channel_mask[i]) w_first = 2'(i);
    end else begin
      for (int i = 3; i >= 0; i--)
        if (bus.channel_mask[i]) w_first = 2'(i);
    end
  end

  // Nearest active channel strictly after r_sel; k = 4 lands on r_sel itself.
  always_comb begin
    w_next = r_sel;
    w_idx  = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      w_idx = w_dir ? r_sel - 2'(k) : r_sel + 2'(k);
      if (bus.channel_mask[w_idx]) w_next = w_idx;
    end
    w_next_wrap = w_dir ? (w_next >= r_sel) : (w_next <= r_sel);
  end

  always_comb begin
    w_state = r_state;
    w_sel   = r_sel;
    w_en    = r_en;
    w_cnt   = r_cnt;
    w_step  = 1'b0;
    w_wrap  = 1'b0;
    if (bus.force_en) begin
      w_state = FORCED;
      w_sel   = bus.force_select;
      w_en    = 1'b1;
      w_cnt   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_en  = 1'b0;
          w_cnt = '0;
          if (bus.run && |bus.channel_mask) begin
            w_state = SCAN;
            w_sel   = w_first;
            w_en    = 1'b1;
          end
        end
        SCAN: begin
          if (!bus.run || ~|bus.channel_mask) begin
            w_state = IDLE;
            w_en    = 1'b0;
            w_cnt   = '0;
          end else if (!bus.channel_mask[r_sel] || r_cnt == LAST) begin
            w_sel  = w_next;
            w_cnt  = '0;
            w_step = 1'b1;
            w_wrap = w_next_wrap;
          end else begin
            w_cnt = r_cnt + CNT_WIDTH'(1);
          end
        end
        FORCED: begin
          w_state = IDLE;
          w_en    = 1'b0;
          w_cnt   = '0;
        end
        default: begin
          w_state = IDLE;
          w_en    = 1'b0;
          w_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_sel   <= 2'd0;
      r_en    <= 1'b0;
      r_step  <= 1'b0;
      r_wrap  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_sel   <= w_sel;
      r_en    <= w_en;
      r_step  <= w_step;
      r_wrap  <= w_wrap;
      r_cnt   <= w_cnt;
    end
  end

  assign bus.select     = r_sel;
  assign bus.enable     = r_en;
  assign bus.step_pulse = r_step;
  assign bus.wrap_pulse = r_wrap;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// tb_mux_select_sequencer: directed scenarios plus a randomized run
// compared against a channel-level reference model (DWELL_CYCLES = 4).
module tb_mux_select_sequencer;

  localparam int DW = 4;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  mux_select_sequencer_if bus ();

  mux_select_sequencer #(
    .DWELL_CYCLES(DW),
    .CNT_WIDTH(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: 0 idle, 1 scanning, 2 forced; m_age = cycles on channel.
  int         m_mode;
  int         m_age;
  logic [1:0] m_sel;
  logic       m_en;
  logic       m_step;
  logic       m_wrap;

  function automatic bit m_desc();
`ifdef MUX_SEQ_DIRECTION_EN
    return bus.direction;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_next(int cur, logic [3:0] mask, bit dsc);
    int best;
    int bestd;
    int d;
    best  = cur;
    bestd = 5;
    for (int c = 0; c < 4; c++) begin
      if (mask[c]) begin
        d = dsc ? (cur - c + 4) % 4 : (c - cur + 4) % 4;
        if (d == 0) d = 4;
        if (d < bestd) begin
          bestd = d;
          best  = c;
        end
      end
    end
    return best;
  endfunction

  function automatic int m_start(logic [3:0] mask, bit dsc);
    int lo;
    int hi;
    lo = -1;
    hi = -1;
    for (int c = 0; c < 4; c++) begin
      if (mask[c] && lo < 0) lo = c;
      if (mask[c]) hi = c;
    end
    return dsc ? hi : lo;
  endfunction

  task automatic model_step();
    int nxt;
    m_step = 1'b0;
    m_wrap = 1'b0;
    if (reset) begin
      m_mode = 0;
      m_sel  = 2'd0;
      m_en   = 1'b0;
      m_age  = 0;
    end else if (bus.force_en) begin
      m_mode = 2;
      m_sel  = bus.force_select;
      m_en   = 1'b1;
      m_age  = 0;
    end else if (m_mode == 2) begin
      m_mode = 0;
      m_en   = 1'b0;
    end else if (m_mode == 0) begin
      if (bus.run && bus.channel_mask != 4'd0) begin
        m_mode = 1;
        m_sel  = 2'(m_start(bus.channel_mask, m_desc()));
        m_en   = 1'b1;
        m_age  = 0;
      end
    end else begin
      if (!bus.run || bus.channel_mask == 4'd0) begin
        m_mode = 0;
        m_en   = 1'b0;
      end else if (!bus.channel_mask[m_sel] || m_age + 1 >= DW) begin
        nxt    = m_next(int'(m_sel), bus.channel_mask, m_desc());
        m_wrap = m_desc() ? (nxt >= int'(m_sel)) : (nxt <= int'(m_sel));
        m_step = 1'b1;
        m_sel  = 2'(nxt);
        m_age  = 0;
      end else begin
        m_age = m_age + 1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset            = 1'b1;
    bus.run          = 1'b0;
    bus.channel_mask = 4'd0;
    bus.force_en     = 1'b0;
    bus.force_select = 2'd0;
`ifdef MUX_SEQ_DIRECTION_EN
    bus.direction    = 1'b0;
`endif
    tick();
    tick();
    checks++;
    if (bus.select !== 2'd0 || bus.enable !== 1'b0 ||
        bus.step_pulse !== 1'b0 || bus.wrap_pulse !== 1'b0) begin
      failures++;
      $display("FAIL reset_state sel=%0d en=%0d step=%0d wrap=%0d want 0 0 0 0",
               bus.select, bus.enable, bus.step_pulse, bus.wrap_pulse);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus.select !== 2'd0 || bus.enable !== 1'b0 ||
          bus.step_pulse !== 1'b0 || bus.wrap_pulse !== 1'b0) begin
        failures++;
        $display("FAIL idle_hold cyc=%0d sel=%0d en=%0d step=%0d wrap=%0d want 0 0 0 0",
                 i, bus.select, bus.enable, bus.step_pulse, bus.wrap_pulse);
      end
    end
  endtask

  task automatic test_basic_scan();
    logic [1:0] es;
    logic       ep;
    do_reset();
    bus.channel_mask = 4'b1111;
    bus.run          = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      es = 2'(((k - 1) / DW) % 4);
      ep = (k > 1) && ((k - 1) % DW == 0);
      checks++;
      if (bus.select !== es || bus.enable !== 1'b1 ||
          bus.step_pulse !== ep || bus.wrap_pulse !== (ep && es == 2'd0)) begin
        failures++;
        $display("FAIL basic_scan k=%0d sel=%0d en=%0d step=%0d wrap=%0d want %0d 1 %0d %0d",
                 k, bus.select, bus.enable, bus.step_pulse, bus.wrap_pulse,
                 es, ep, ep && es == 2'd0);
      end
    end
    bus.run = 1'b0;
    tick();
    checks++;
    if (bus.enable !== 1'b0 || bus.select !== 2'd0 || bus.step_pulse !== 1'b0) begin
      failures++;
      $display("FAIL run_stop en=%0d sel=%0d step=%0d want 0 0 0",
               bus.enable, bus.select, bus.step_pulse);
    end
  endtask

  task automatic test_skip();
    logic [1:0] es;
    logic       ep;
    do_reset();
    bus.channel_mask = 4'b1010;
    bus.run          = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      es = (((k - 1) / DW) % 2 == 1) ? 2'd3 : 2'd1;
      ep = (k > 1) && ((k - 1) % DW == 0);
      checks++;
      if (bus.select !== es || bus.step_pulse !== ep ||
          bus.wrap_pulse !== (ep && es == 2'd1)) begin
        failures++;
        $display("FAIL skip_1010 k=%0d sel=%0d step=%0d wrap=%0d want %0d %0d %0d",
                 k, bus.select, bus.step_pulse, bus.wrap_pulse, es, ep, ep && es == 2'd1);
      end
    end
    do_reset();
    bus.channel_mask = 4'b0100;
    for (int k = 1; k <= 13; k++) begin
      tick();
      ep = (k > 1) && ((k - 1) % DW == 0);
      checks++;
      if (bus.select !== 2'd2 || bus.enable !== 1'b1 ||
          bus.step_pulse !== ep || bus.wrap_pulse !== ep) begin
        failures++;
        $display("FAIL single_ch k=%0d sel=%0d en=%0d step=%0d wrap=%0d want 2 1 %0d %0d",
                 k, bus.select, bus.enable, bus.step_pulse, bus.wrap_pulse, ep, ep);
      end
    end
  endtask

  task automatic test_mask_change();
    do_reset();
    bus.channel_mask = 4'b0111;
    bus.run          = 1'b1;
    repeat (10) tick();
    checks++;
    if (bus.select !== 2'd2) begin
      failures++;
      $display("FAIL mask_pre sel=%0d want 2", bus.select);
    end
    bus.channel_mask = 4'b0011;
    tick();
    checks++;
    if (bus.select !== 2'd0 || bus.step_pulse !== 1'b1 ||
        bus.wrap_pulse !== 1'b1 || bus.enable !== 1'b1) begin
      failures++;
      $display("FAIL mask_drop sel=%0d step=%0d wrap=%0d en=%0d want 0 1 1 1",
               bus.select, bus.step_pulse, bus.wrap_pulse, bus.enable);
    end
    repeat (3) tick();
    checks++;
    if (bus.select !== 2'd0 || bus.step_pulse !== 1'b0) begin
      failures++;
      $display("FAIL mask_restart sel=%0d step=%0d want 0 0", bus.select, bus.step_pulse);
    end
    tick();
    checks++;
    if (bus.select !== 2'd1 || bus.step_pulse !== 1'b1 || bus.wrap_pulse !== 1'b0) begin
      failures++;
      $display("FAIL mask_next sel=%0d step=%0d wrap=%0d want 1 1 0",
               bus.select, bus.step_pulse, bus.wrap_pulse);
    end
    bus.channel_mask = 4'b0000;
    tick();
    checks++;
    if (bus.enable !== 1'b0 || bus.select !== 2'd1 || bus.step_pulse !== 1'b0) begin
      failures++;
      $display("FAIL mask_zero en=%0d sel=%0d step=%0d want 0 1 0",
               bus.enable, bus.select, bus.step_pulse);
    end
  endtask

  task automatic test_force();
    do_reset();
    bus.channel_mask = 4'b1111;
    bus.run          = 1'b1;
    repeat (5) tick();
    bus.force_en     = 1'b1;
    bus.force_select = 2'd3;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) bus.channel_mask = 4'b0000;
      tick();
      checks++;
      if (bus.select !== 2'd3 || bus.enable !== 1'b1 ||
          bus.step_pulse !== 1'b0 || bus.wrap_pulse !== 1'b0) begin
        failures++;
        $display("FAIL force_hold i=%0d sel=%0d en=%0d step=%0d wrap=%0d want 3 1 0 0",
                 i, bus.select, bus.enable, bus.step_pulse, bus.wrap_pulse);
      end
    end
    bus.channel_mask = 4'b1111;
    bus.force_select = 2'd1;
    tick();
    checks++;
    if (bus.select !== 2'd1 || bus.enable !== 1'b1) begin
      failures++;
      $display("FAIL force_track sel=%0d en=%0d want 1 1", bus.select, bus.enable);
    end
    bus.force_en = 1'b0;
    tick();
    checks++;
    if (bus.enable !== 1'b0 || bus.select !== 2'd1 || bus.step_pulse !== 1'b0) begin
      failures++;
      $display("FAIL force_release en=%0d sel=%0d step=%0d want 0 1 0",
               bus.enable, bus.select, bus.step_pulse);
    end
    tick();
    checks++;
    if (bus.enable !== 1'b1 || bus.select !== 2'd0 || bus.step_pulse !== 1'b0) begin
      failures++;
      $display("FAIL force_resume en=%0d sel=%0d step=%0d want 1 0 0",
               bus.enable, bus.select, bus.step_pulse);
    end
    repeat (4) tick();
    checks++;
    if (bus.select !== 2'd1 || bus.step_pulse !== 1'b1) begin
      failures++;
      $display("FAIL force_rescan sel=%0d step=%0d want 1 1", bus.select, bus.step_pulse);
    end
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    bus.channel_mask = 4'b1111;
    bus.run          = 1'b1;
    repeat (9) tick();
    checks++;
    if (bus.select !== 2'd2 || bus.enable !== 1'b1) begin
      failures++;
      $display("FAIL midscan_pre sel=%0d en=%0d want 2 1", bus.select, bus.enable);
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.select !== 2'd0 || bus.enable !== 1'b0 || bus.step_pulse !== 1'b0) begin
        failures++;
        $display("FAIL midscan_reset i=%0d sel=%0d en=%0d step=%0d want 0 0 0",
                 i, bus.select, bus.enable, bus.step_pulse);
      end
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.select !== 2'd0 || bus.enable !== 1'b1 || bus.step_pulse !== 1'b0) begin
      failures++;
      $display("FAIL midscan_restart sel=%0d en=%0d step=%0d want 0 1 0",
               bus.select, bus.enable, bus.step_pulse);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) bus.force_en = ~bus.force_en;
      bus.force_select = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) bus.run = ~bus.run;
      if ($urandom_range(0, 14) == 0) bus.channel_mask = 4'($urandom_range(0, 15));
`ifdef MUX_SEQ_DIRECTION_EN
      if ($urandom_range(0, 29) == 0) bus.direction = ~bus.direction;
`endif
      tick();
      checks++;
      if (bus.select !== m_sel || bus.enable !== m_en ||
          bus.step_pulse !== m_step || bus.wrap_pulse !== m_wrap) begin
        failures++;
        $display("FAIL random cyc=%0d sel=%0d en=%0d step=%0d wrap=%0d want %0d %0d %0d %0d",
                 i, bus.select, bus.enable, bus.step_pulse, bus.wrap_pulse,
                 m_sel, m_en, m_step, m_wrap);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_mode   = 0;
    m_age    = 0;
    m_sel    = 2'd0;
    m_en     = 1'b0;
    m_step   = 1'b0;
    m_wrap   = 1'b0;
    test_reset();
    test_basic_scan();
    test_skip();
    test_mask_change();
    test_force();
    test_reset_mid_scan();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
